// File: rtl/encoder_8b10b_nsym.sv
// rtl/encoder_8b10b_nsym.sv - NSYM-wide 8b/10b encoder with running disparity and valid/ready handshake
//
// Encodes NSYM bytes per clock. Disparity chains from symbol 0 to symbol
// NSYM-1 inside one word; the final disparity is held in rd for the next
// word. Code tables store the RD- column only; the RD+ column is derived by
// complementing where the code is unbalanced or is one of the balanced
// codes that still alternate (D.7 in 5b/6b, D.x.3 and all K codes in 3b/4b).
// Output bits are in transmission order: bit 0 = a ... bit 9 = j.

module encoder_8b10b_nsym #(
  parameter int NSYM = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [8*NSYM-1:0]    data_in,
  input  logic [NSYM-1:0]      k_in,
  input  logic                 in_valid,
  output logic                 in_ready,
  output logic [10*NSYM-1:0]   data_out,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [NSYM-1:0]      code_err,
  output logic                 rd
);

  // 5b/6b RD- column, written abcdei with a in the MSB.
  function automatic logic [5:0] lut6_rdm(input logic [4:0] x);
    logic [5:0] c;
    case (x)
      5'd0:    c = 6'b100111;
      5'd1:    c = 6'b011101;
      5'd2:    c = 6'b101101;
      5'd3:    c = 6'b110001;
      5'd4:    c = 6'b110101;
      5'd5:    c = 6'b101001;
      5'd6:    c = 6'b011001;
      5'd7:    c = 6'b111000;
      5'd8:    c = 6'b111001;
      5'd9:    c = 6'b100101;
      5'd10:   c = 6'b010101;
      5'd11:   c = 6'b110100;
      5'd12:   c = 6'b001101;
      5'd13:   c = 6'b101100;
      5'd14:   c = 6'b011100;
      5'd15:   c = 6'b010111;
      5'd16:   c = 6'b011011;
      5'd17:   c = 6'b100011;
      5'd18:   c = 6'b010011;
      5'd19:   c = 6'b110010;
      5'd20:   c = 6'b001011;
      5'd21:   c = 6'b101010;
      5'd22:   c = 6'b011010;
      5'd23:   c = 6'b111010;
      5'd24:   c = 6'b110011;
      5'd25:   c = 6'b100110;
      5'd26:   c = 6'b010110;
      5'd27:   c = 6'b110110;
      5'd28:   c = 6'b001110;
      5'd29:   c = 6'b101110;
      5'd30:   c = 6'b011110;
      default: c = 6'b101011;
    endcase
    return c;
  endfunction

  // 3b/4b data RD- column, written fghj with f in the MSB (D.x.P7 at y=7).
  function automatic logic [3:0] lut4_data_rdm(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b1001;
      3'd2:    c = 4'b0101;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b1010;
      3'd6:    c = 4'b0110;
      default: c = 4'b1110;
    endcase
    return c;
  endfunction

  // 3b/4b control RD- column; every K code alternates with disparity.
  function automatic logic [3:0] lut4_k_rdm(input logic [2:0] y);
    logic [3:0] c;
    case (y)
      3'd0:    c = 4'b1011;
      3'd1:    c = 4'b0110;
      3'd2:    c = 4'b1010;
      3'd3:    c = 4'b1100;
      3'd4:    c = 4'b1101;
      3'd5:    c = 4'b0101;
      3'd6:    c = 4'b1001;
      default: c = 4'b0111;
    endcase
    return c;
  endfunction

  // One symbol: returns {code_err, disparity after symbol, 10-bit group}.
  function automatic logic [11:0] enc_sym(input logic [7:0] d, input logic k, input logic rd_in);
    logic [4:0] x;
    logic [2:0] y;
    logic       legal_k;
    logic       err;
    logic       unbal6;
    logic       unbal4;
    logic       rd6;
    logic       alt7;
    logic [5:0] c6;
    logic [3:0] c4;
    logic [9:0] code;
    x = d[4:0];
    y = d[7:5];
    legal_k = (x == 5'd28) ||
              ((y == 3'd7) && ((x == 5'd23) || (x == 5'd27) || (x == 5'd29) || (x == 5'd30)));
    err = k && !legal_k;
    // An unsupported control byte is replaced by the comma K28.5.
    if (err) begin
      x = 5'd28;
      y = 3'd5;
    end
    if (k && (x == 5'd28)) begin
      c6 = 6'b001111;
    end else begin
      c6 = lut6_rdm(x);
    end
    unbal6 = ($countones(c6) != 3);
    if (rd_in && (unbal6 || (x == 5'd7))) begin
      c6 = ~c6;
    end
    rd6 = rd_in ^ unbal6;
    if (k) begin
      c4 = lut4_k_rdm(y);
      if (rd6) begin
        c4 = ~c4;
      end
    end else begin
      // A7 avoids a run of five identical bits across the e/i and f/g boundary.
      alt7 = (y == 3'd7) &&
             (rd6 ? ((x == 5'd11) || (x == 5'd13) || (x == 5'd14))
                  : ((x == 5'd17) || (x == 5'd18) || (x == 5'd20)));
      c4 = alt7 ? 4'b0111 : lut4_data_rdm(y);
      if (rd6 && (($countones(c4) != 2) || (y == 3'd3))) begin
        c4 = ~c4;
      end
    end
    unbal4 = ($countones(c4) != 2);
    code = {c4[0], c4[1], c4[2], c4[3], c6[0], c6[1], c6[2], c6[3], c6[4], c6[5]};
    return {err, rd6 ^ unbal4, code};
  endfunction

  logic [10*NSYM-1:0] enc_word;
  logic [NSYM-1:0]    enc_err;
  logic               rd_next;
  logic               accept;

  assign in_ready = !out_valid || out_ready;
  assign accept   = in_valid && in_ready;

  // Encode all symbols of the input word, chaining disparity from rd.
  always_comb begin
    logic        chain;
    logic [11:0] res;
    chain    = rd;
    res      = '0;
    enc_word = '0;
    enc_err  = '0;
    for (int i = 0; i < NSYM; i++) begin
      res                 = enc_sym(data_in[8*i +: 8], k_in[i], chain);
      enc_word[10*i +: 10] = res[9:0];
      enc_err[i]          = res[11];
      chain               = res[10];
    end
    rd_next = chain;
  end

  // Output register stage; rd advances only when a word is accepted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      data_out  <= '0;
      code_err  <= '0;
      out_valid <= 1'b0;
      rd        <= 1'b0;
    end else if (accept) begin
      data_out  <= enc_word;
      code_err  <= enc_err;
      out_valid <= 1'b1;
      rd        <= rd_next;
    end else if (out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_encoder_8b10b_nsym.sv
// tb/tb_encoder_8b10b_nsym.sv - directed and random-stream bench for encoder_8b10b_nsym
module tb_encoder_8b10b_nsym;

  localparam int NSYM   = 2;
  localparam int NWORDS = 10000;

  logic                 clk;
  logic                 rst;
  logic [8*NSYM-1:0]    data_in;
  logic [NSYM-1:0]      k_in;
  logic                 in_valid;
  logic                 in_ready;
  logic [10*NSYM-1:0]   data_out;
  logic                 out_valid;
  logic                 out_ready;
  logic [NSYM-1:0]      code_err;
  logic                 rd;

  int n_checks;
  int n_fail;

  logic [10*NSYM-1:0] exp_q[$];
  logic [NSYM-1:0]    err_q[$];

  encoder_8b10b_nsym #(.NSYM(NSYM)) dut (
    .clk(clk),
    .rst(rst),
    .data_in(data_in),
    .k_in(k_in),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .data_out(data_out),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .code_err(code_err),
    .rd(rd)
  );

  always #5 clk = ~clk;

  // Reference 5b/6b table: {RD- column, RD+ column}, abcdei MSB first.
  function automatic logic [11:0] tab6(input logic [4:0] x);
    case (x)
      5'd0:  return {6'b100111, 6'b011000};
      5'd1:  return {6'b011101, 6'b100010};
      5'd2:  return {6'b101101, 6'b010010};
      5'd3:  return {6'b110001, 6'b110001};
      5'd4:  return {6'b110101, 6'b001010};
      5'd5:  return {6'b101001, 6'b101001};
      5'd6:  return {6'b011001, 6'b011001};
      5'd7:  return {6'b111000, 6'b000111};
      5'd8:  return {6'b111001, 6'b000110};
      5'd9:  return {6'b100101, 6'b100101};
      5'd10: return {6'b010101, 6'b010101};
      5'd11: return {6'b110100, 6'b110100};
      5'd12: return {6'b001101, 6'b001101};
      5'd13: return {6'b101100, 6'b101100};
      5'd14: return {6'b011100, 6'b011100};
      5'd15: return {6'b010111, 6'b101000};
      5'd16: return {6'b011011, 6'b100100};
      5'd17: return {6'b100011, 6'b100011};
      5'd18: return {6'b010011, 6'b010011};
      5'd19: return {6'b110010, 6'b110010};
      5'd20: return {6'b001011, 6'b001011};
      5'd21: return {6'b101010, 6'b101010};
      5'd22: return {6'b011010, 6'b011010};
      5'd23: return {6'b111010, 6'b000101};
      5'd24: return {6'b110011, 6'b001100};
      5'd25: return {6'b100110, 6'b100110};
      5'd26: return {6'b010110, 6'b010110};
      5'd27: return {6'b110110, 6'b001001};
      5'd28: return {6'b001110, 6'b001110};
      5'd29: return {6'b101110, 6'b010001};
      5'd30: return {6'b011110, 6'b100001};
      default: return {6'b101011, 6'b010100};
    endcase
  endfunction

  function automatic logic [7:0] tab4d(input logic [2:0] y);
    case (y)
      3'd0: return {4'b1011, 4'b0100};
      3'd1: return {4'b1001, 4'b1001};
      3'd2: return {4'b0101, 4'b0101};
      3'd3: return {4'b1100, 4'b0011};
      3'd4: return {4'b1101, 4'b0010};
      3'd5: return {4'b1010, 4'b1010};
      3'd6: return {4'b0110, 4'b0110};
      default: return {4'b1110, 4'b0001};
    endcase
  endfunction

  function automatic logic [7:0] tab4k(input logic [2:0] y);
    case (y)
      3'd0: return {4'b1011, 4'b0100};
      3'd1: return {4'b0110, 4'b1001};
      3'd2: return {4'b1010, 4'b0101};
      3'd3: return {4'b1100, 4'b0011};
      3'd4: return {4'b1101, 4'b0010};
      3'd5: return {4'b0101, 4'b1010};
      3'd6: return {4'b1001, 4'b0110};
      default: return {4'b0111, 4'b1000};
    endcase
  endfunction

  // Reference symbol encoder: {err, rd after, group with a at bit 0}.
  function automatic logic [11:0] ref_enc(input logic [7:0] d, input logic k, input logic rd_i);
    logic [7:0]  dd;
    logic [4:0]  x;
    logic [2:0]  y;
    logic [11:0] t6;
    logic [7:0]  t4;
    logic [5:0]  s6;
    logic [3:0]  s4;
    logic        r;
    logic        e;
    logic [9:0]  c;
    dd = d;
    e  = 1'b0;
    if (k && !(dd == 8'h1C || dd == 8'h3C || dd == 8'h5C || dd == 8'h7C ||
               dd == 8'h9C || dd == 8'hBC || dd == 8'hDC || dd == 8'hFC ||
               dd == 8'hF7 || dd == 8'hFB || dd == 8'hFD || dd == 8'hFE)) begin
      e  = 1'b1;
      dd = 8'hBC;
    end
    x = dd[4:0];
    y = dd[7:5];
    if (k && x == 5'd28) t6 = {6'b001111, 6'b110000};
    else t6 = tab6(x);
    r  = rd_i;
    s6 = r ? t6[5:0] : t6[11:6];
    if ($countones(s6) != 3) r = ~r;
    if (k) t4 = tab4k(y);
    else if (y == 3'd7 && ((!r && (x == 5'd17 || x == 5'd18 || x == 5'd20)) ||
                           (r && (x == 5'd11 || x == 5'd13 || x == 5'd14))))
      t4 = {4'b0111, 4'b1000};
    else t4 = tab4d(y);
    s4 = r ? t4[3:0] : t4[7:4];
    if ($countones(s4) != 2) r = ~r;
    for (int j = 0; j < 6; j++) c[j] = s6[5-j];
    for (int j = 0; j < 4; j++) c[6+j] = s4[3-j];
    return {e, r, c};
  endfunction

  task automatic test_reset;
    #2;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid: got %b expected 0", out_valid); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL reset_data_out: got %h expected 0", data_out); end
    n_checks++; if (code_err !== '0) begin n_fail++; $display("FAIL reset_code_err: got %b expected 0", code_err); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL reset_rd: got %b expected 0", rd); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL reset_in_ready: got %b expected 1", in_ready); end
    in_valid = 1'b1;
    data_in  = 16'hBCBC;
    k_in     = 2'b11;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_no_accept: got %b expected 0", out_valid); end
    @(negedge clk);
    rst      = 1'b0;
    in_valid = 1'b0;
  endtask

  task automatic test_k28_5;
    @(negedge clk);
    data_in = 16'hBCBC; k_in = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (data_out[9:0] !== 10'h17C) begin n_fail++; $display("FAIL k28_5_sym0: got %h expected 17c", data_out[9:0]); end
    n_checks++; if (data_out[19:10] !== 10'h283) begin n_fail++; $display("FAIL k28_5_sym1: got %h expected 283", data_out[19:10]); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL k28_5_rd: got %b expected 0", rd); end
    n_checks++; if (code_err !== 2'b00) begin n_fail++; $display("FAIL k28_5_err: got %b expected 00", code_err); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL k28_5_valid: got %b expected 1", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL k28_5_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_data;
    @(negedge clk);
    data_in = 16'hB500; k_in = 2'b00; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (data_out !== {10'h155, 10'h0B9}) begin n_fail++; $display("FAIL data_d0_d21_5: got %h expected %h", data_out, {10'h155, 10'h0B9}); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL data_rd: got %b expected 0", rd); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_illegal_k;
    @(negedge clk);
    data_in = 16'h2300; k_in = 2'b01; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (data_out !== {10'h263, 10'h17C}) begin n_fail++; $display("FAIL illegal_k_data: got %h expected %h", data_out, {10'h263, 10'h17C}); end
    n_checks++; if (code_err !== 2'b01) begin n_fail++; $display("FAIL illegal_k_err: got %b expected 01", code_err); end
    n_checks++; if (rd !== 1'b1) begin n_fail++; $display("FAIL illegal_k_rd: got %b expected 1", rd); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure;
    @(negedge clk);
    data_in = 16'h00BC; k_in = 2'b01; in_valid = 1'b1; out_ready = 1'b0;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_ready_idle: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (data_out !== {10'h0B9, 10'h283}) begin n_fail++; $display("FAIL bp_first: got %h expected %h", data_out, {10'h0B9, 10'h283}); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL bp_first_rd: got %b expected 0", rd); end
    data_in = 16'hBCBC; k_in = 2'b11;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      n_checks++; if (in_ready !== 1'b0) begin n_fail++; $display("FAIL bp_stall_ready: cycle %0d got %b expected 0", c, in_ready); end
      n_checks++; if (data_out !== {10'h0B9, 10'h283}) begin n_fail++; $display("FAIL bp_stall_data: cycle %0d got %h expected %h", c, data_out, {10'h0B9, 10'h283}); end
      n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_stall_valid: cycle %0d got %b expected 1", c, out_valid); end
      n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL bp_stall_rd: cycle %0d got %b expected 0", c, rd); end
    end
    @(negedge clk);
    out_ready = 1'b1;
    #1;
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL bp_release_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (data_out !== {10'h283, 10'h17C}) begin n_fail++; $display("FAIL bp_next_word: got %h expected %h", data_out, {10'h283, 10'h17C}); end
    n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL bp_next_valid: got %b expected 1", out_valid); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL bp_drain: got %b expected 0", out_valid); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    data_in = 16'h23BC; k_in = 2'b01; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    n_checks++; if (data_out !== {10'h263, 10'h17C} || rd !== 1'b1) begin n_fail++; $display("FAIL rstmid_setup: got %h rd %b expected %h rd 1", data_out, rd, {10'h263, 10'h17C}); end
    #2;
    rst = 1'b1;
    #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_valid: got %b expected 0", out_valid); end
    n_checks++; if (rd !== 1'b0) begin n_fail++; $display("FAIL rstmid_rd: got %b expected 0", rd); end
    n_checks++; if (data_out !== '0) begin n_fail++; $display("FAIL rstmid_data: got %h expected 0", data_out); end
    n_checks++; if (in_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_ready: got %b expected 1", in_ready); end
    @(posedge clk); #1;
    n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL rstmid_hold: got %b expected 0", out_valid); end
    @(negedge clk);
    rst = 1'b0;
    data_in = 16'hBCBC; k_in = 2'b11; in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    n_checks++; if (data_out !== {10'h283, 10'h17C}) begin n_fail++; $display("FAIL rstmid_post: got %h expected %h", data_out, {10'h283, 10'h17C}); end
    @(negedge clk);
    in_valid = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_random_stream;
    logic [7:0]          kl [12];
    logic [10*NSYM-1:0]  ew;
    logic [NSYM-1:0]     ee;
    logic [11:0]         r;
    logic [7:0]          b;
    logic                mrd;
    logic                acc;
    logic                con;
    logic                bit_v;
    logic                last_bit;
    int                  sent;
    int                  cyc;
    int                  run;
    int                  run_max;
    int                  cum;
    kl[0] = 8'h1C; kl[1] = 8'h3C; kl[2] = 8'h5C; kl[3] = 8'h7C;
    kl[4] = 8'h9C; kl[5] = 8'hBC; kl[6] = 8'hDC; kl[7] = 8'hFC;
    kl[8] = 8'hF7; kl[9] = 8'hFB; kl[10] = 8'hFD; kl[11] = 8'hFE;
    @(negedge clk);
    rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    exp_q.delete(); err_q.delete();
    mrd = 1'b0; sent = 0; cyc = 0; run = 0; run_max = 0; cum = -1; last_bit = 1'bx;
    while ((sent < NWORDS || exp_q.size() > 0) && cyc < 60000) begin
      @(negedge clk);
      in_valid = (sent < NWORDS) && ($urandom_range(3) != 0);
      for (int i = 0; i < NSYM; i++) begin
        k_in[i] = ($urandom_range(7) == 0);
        if (k_in[i] && $urandom_range(3) != 0) b = kl[$urandom_range(11)];
        else b = 8'($urandom_range(255));
        data_in[8*i +: 8] = b;
      end
      out_ready = ($urandom_range(2) != 0);
      #1;
      acc = in_valid && in_ready;
      con = out_valid && out_ready;
      if (con) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++; $display("FAIL rand_spurious: out_valid with no expected word, data %h", data_out);
        end else begin
          ew = exp_q.pop_front();
          ee = err_q.pop_front();
          if (data_out !== ew || code_err !== ee) begin
            n_fail++; $display("FAIL rand_word: got %h err %b expected %h err %b", data_out, code_err, ew, ee);
          end
        end
        for (int i = 0; i < NSYM; i++) begin
          for (int j = 0; j < 10; j++) begin
            bit_v = data_out[10*i + j];
            if (bit_v === last_bit) run++;
            else run = 1;
            last_bit = bit_v;
            if (run > run_max) run_max = run;
          end
          cum = cum + 2 * $countones(data_out[10*i +: 10]) - 10;
          n_checks++; if (cum != -1 && cum != 1) begin n_fail++; $display("FAIL rand_cum_disparity: got %0d expected -1 or 1", cum); end
          n_checks++; if (run_max > 5) begin n_fail++; $display("FAIL rand_run_length: got %0d expected at most 5", run_max); end
        end
      end
      if (acc) begin
        for (int i = 0; i < NSYM; i++) begin
          r = ref_enc(data_in[8*i +: 8], k_in[i], mrd);
          ew[10*i +: 10] = r[9:0];
          ee[i] = r[11];
          mrd = r[10];
        end
        exp_q.push_back(ew);
        err_q.push_back(ee);
        sent++;
      end
      @(posedge clk); #1;
      n_checks++; if (out_valid !== (exp_q.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid: got %b expected %b", out_valid, exp_q.size() > 0); end
      n_checks++; if (rd !== mrd) begin n_fail++; $display("FAIL rand_rd: got %b expected %b", rd, mrd); end
      cyc++;
    end
    in_valid = 1'b0;
    n_checks++;
    if (sent != NWORDS || exp_q.size() != 0) begin
      n_fail++; $display("FAIL rand_timeout: sent %0d of %0d, %0d words pending", sent, NWORDS, exp_q.size());
    end
  endtask

  initial begin
    clk = 1'b0; rst = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    data_in = '0; k_in = '0;
    n_checks = 0; n_fail = 0;
    test_reset();
    test_k28_5();
    test_data();
    test_illegal_k();
    test_backpressure();
    test_reset_mid();
    test_random_stream();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/encoder_8b10b_nsym.md
ENCODER_8B10B_NSYM -- requirements
Module: encoder_8b10b_nsym

Interface
REQ-001 SHALL provide parameter: NSYM, default 2, number of byte symbols encoded per clock (1..8).
REQ-002 SHALL provide ports:
- clk  input  1  rising-edge clock for all state.
- rst  input  1  reset; asynchronous, active-high.
- data_in  input  8*NSYM  symbol i in bits [8i+7:8i]; bits 7:5 = HGF, bits 4:0 = EDCBA.
- k_in  input  NSYM  bit i high: symbol i is a control (K) character.
- in_valid  input  1  input word present.
- in_ready  output  1  encoder can accept a word this cycle.
- data_out  output  10*NSYM  code group i in bits [10i+9:10i]; bit 0 = a (first transmitted) through bit 9 = j; order abcdeifghj.
- out_valid  output  1  data_out holds a valid word.
- out_ready  input  1  downstream accepts the word this cycle.
- code_err  output  NSYM  bit i high: symbol i was an illegal K code.
- rd  output  1  running disparity after the last accepted word; 0 = RD-, 1 = RD+.

Function
REQ-003 SHALL encode each symbol per the standard 8b/10b (IEEE 802.3 Clause 36) 5b/6b and 3b/4b tables, selecting columns by the running disparity at that symbol.
REQ-004 SHALL chain disparity within a word: symbol 0 uses rd; symbol i uses the disparity resulting from symbol i-1.
REQ-005 SHALL compute disparity per sub-block: a non-neutral 6b or 4b sub-block flips disparity; neutral sub-blocks keep it; 4b column selection uses disparity after the 6b sub-block.
REQ-006 SHALL apply the alternate D.x.7 encoding (A7) when required: RD- with x in {17,18,20}, RD+ with x in {11,13,14}.
REQ-007 SHALL accept K only for K28.0-K28.7, K23.7, K27.7, K29.7, K30.7; any other K byte SHALL be encoded as K28.5 at the current disparity, with the corresponding code_err bit set.
REQ-008 SHALL assert in_ready = !out_valid || out_ready (combinational); a word transfers in when in_valid && in_ready.
REQ-009 SHALL register the encoded word, code_err and out_valid=1 on the clock edge of an accepted input; latency 1 cycle from acceptance to out_valid.
REQ-010 SHALL clear out_valid when out_ready is high and no new input is accepted in the same cycle.
REQ-011 SHALL hold data_out and code_err stable while out_valid && !out_ready.
REQ-012 SHALL update rd on the same edge as acceptance, to the disparity after symbol NSYM-1; rd SHALL NOT change in any other cycle.
REQ-013 SHALL support full throughput: simultaneous output consumption and input acceptance every cycle without bubbles.
REQ-014 SHALL ignore data_in and k_in when in_valid is low or in_ready is low.

Reset
REQ-015 SHALL, while rst is high, immediately force data_out=0, code_err=0, out_valid=0, rd=0 (RD-), independent of clk.
REQ-016 SHALL drop an in-flight output word on reset mid-operation; the first word accepted after reset release SHALL encode from RD-.
REQ-017 SHALL keep in_ready high while rst is asserted (out_valid=0); no acceptance occurs while rst is high.

Verification
REQ-018 NSYM=2, after reset, one word K28.5,K28.5 (data_in=16'hBCBC, k_in=2'b11), out_ready=1 -> next cycle data_out[9:0]=10'h17C, data_out[19:10]=10'h283, rd=0, code_err=0.
REQ-019 NSYM=2, RD-, D0.0,D21.5 (data_in=16'hB500, k_in=0) -> data_out[9:0]=10'h0B9, data_out[19:10]=10'h155, rd stays 0.
REQ-020 Illegal K: data_in[7:0]=8'h00, k_in[0]=1 at RD- -> data_out[9:0]=10'h17C, code_err[0]=1, rd reflects K28.5 disparity flip.
REQ-021 Backpressure: out_ready=0 for 3 cycles with in_valid=1 -> in_ready=0 after first accept, data_out unchanged, rd unchanged; out_ready=1 -> word consumed and next word accepted same cycle.
REQ-022 Reset mid-stream: assert rst between clock edges with out_valid=1, rd=1 -> out_valid=0, rd=0 immediately; post-release K28.5 encodes as 10'h17C.
REQ-023 Random stream of 10^4 words with random backpressure -> every output group matches a reference model, cumulative disparity of transmitted stream stays within +/-1, run length of identical bits never exceeds 5.
